zion_riscv_addsub_arbiter: RTL
==============================

# zion_riscv_addsub_arbiter

Shares one RV32 add/sub + less-than execution datapath among `NUM_REQ` requesters, e.g. the ALU issue port, the branch comparator and the address generator. Each requester offers an operation over a valid/ready channel. A round-robin arbiter grants one per cycle, and the shared datapath computes sum/difference and less-than. The result is captured in a single-entry output buffer and returned on one response channel tagged with the requester index. The block sits between the issue stage and the writeback/branch-resolve logic.

## Interface
- `XLEN`, 32: operand and result width.
- `NUM_REQ`, 2: number of requesters, 2..8.
- `IDW`, `$clog2(NUM_REQ)`: requester-id width. Derived, not overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_vld`  in  NUM_REQ  per-requester request valid.
- `req_rdy`  out  NUM_REQ  per-requester grant; the handshake completes when `req_vld[i] & req_rdy[i]`.
- `req_op`  in  2*NUM_REQ  op of requester i at `[2i+1:2i]`: 2'b01 add, 2'b10 sub, other values illegal.
- `req_uns`  in  NUM_REQ  compare type for sub: 1 unsigned, 0 signed.
- `req_s1`  in  XLEN*NUM_REQ  operand 1 of requester i at `[XLEN*i +: XLEN]`.
- `req_s2`  in  XLEN*NUM_REQ  operand 2 of requester i, same packing.
- `rsp_vld`  out  1  response valid.
- `rsp_rdy`  in  1  consumer ready; the handshake completes when `rsp_vld & rsp_rdy`.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_rslt`  out  XLEN  sum or difference.
- `rsp_lt`  out  1  less-than result, valid for sub only.
- `rsp_err`  out  1  the op was illegal.

## Operation
- **Slot.** A single response register, `full` = `rsp_vld`.
  - `slot_free = ~rsp_vld | rsp_rdy`.
  - The arbiter grants only when `slot_free`. A consumer draining the slot in the same cycle allows a new capture in that cycle.
- **Arbitration.** Round-robin over the asserted `req_vld` bits, starting at pointer `ptr`.
  - At most one `req_rdy` bit is high.
  - `req_rdy` is combinational from `req_vld`, `ptr` and `slot_free`, with no dependence on operands.
  - On grant to requester i, `ptr` is set to (i+1) mod NUM_REQ. Otherwise `ptr` holds.
- **Datapath (granted requester).**
  - op 01: `rslt = s1 + s2` mod 2^XLEN, `lt = 0`, `err = 0`.
  - op 10: `rslt = s1 - s2` mod 2^XLEN, `err = 0`.
    - `lt` is computed from an XLEN+1-bit subtraction.
    - Unsigned: operands are zero-extended; `lt` = borrow bit.
    - Signed: operands are sign-extended; `lt` = bit XLEN of the difference.
  - op 00/11: the request is accepted and consumed; `rslt = 0`, `lt = 0`, `err = 1`.
- **Capture.** On grant, `rsp_id`, `rsp_rslt`, `rsp_lt` and `rsp_err` are registered and `rsp_vld` is set.
  - If there is no grant and `rsp_rdy` is high, `rsp_vld` clears and the payload holds.
  - Payload is stable while `rsp_vld & ~rsp_rdy`.
- **Requesters.** A requester must hold `req_*` stable while `req_vld & ~req_rdy`. The block does not check this.

## Timing
- Reset values (asynchronous): `rsp_vld = 0`, `rsp_id = 0`, `rsp_rslt = 0`, `rsp_lt = 0`, `rsp_err = 0`, `ptr = 0`. `req_rdy` is 0 for every requester because `req_vld` is ignored while `rst` is high.
- Latency: accepted in cycle N, response visible in cycle N+1.
- Throughput: one operation per cycle while `rsp_rdy` is high.
- Backpressure: with `rsp_vld` high and `rsp_rdy` low, every `req_rdy` is 0 and `ptr` holds.
- Fairness: a continuously requesting source waits at most NUM_REQ-1 grants.
- Reset mid-operation: a pending response is discarded and no stale response appears after reset release.
- First cycle after reset release: grants may occur immediately.

## Test plan
- **Single requester, add.** Requester 0 sends op 01, s1=0x7FFFFFFF, s2=1. Expect `req_rdy[0]` in the same cycle and, next cycle, `rsp_vld=1`, `rsp_id=0`, `rslt=0x80000000`, `lt=0`, `err=0`.
- **Sub / less-than, requester 1.**
  - op 10, s1=0xFFFFFFFF, s2=1, signed: `rslt=0xFFFFFFFE`, `lt=1`.
  - Same operands, unsigned: `lt=0`.
  - s1=5, s2=5: `rslt=0`, `lt=0`.
- **Round-robin.** Both requesters hold valid for 4 cycles with `rsp_rdy=1`. Expect grants 0,1,0,1 and 4 back-to-back responses with ids 0,1,0,1.
- **Backpressure.** `rsp_rdy=0` for 3 cycles with both requesters valid. Expect one response held stable, all `req_rdy=0`, and `ptr` unchanged. On `rsp_rdy=1`, expect a new grant in the same cycle and the next response in the following cycle.
- **Illegal op and reset.**
  - op 11 from requester 0: accepted, response `err=1`, `rslt=0`.
  - Assert `rst` while `rsp_vld=1`: outputs go to zero immediately, and after release the first grant goes to requester 0.
- **Random scoreboard.** Random ops, operands, `uns` and `rsp_rdy` over ≥2000 cycles with NUM_REQ=4. Every accepted request gets exactly one response, in order, with the correct id and results matching a reference model.

Source files
------------

// File: rtl/zion_riscv_addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub + less-than datapath among NUM_REQ requesters.
// Results land in a single-entry response register tagged with the winning requester index.
module zion_riscv_addsub_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_vld_i,
  output logic [NUM_REQ-1:0]           req_rdy_o,
  input  logic [2*NUM_REQ-1:0]         req_op_i,
  input  logic [NUM_REQ-1:0]           req_uns_i,
  input  logic [XLEN*NUM_REQ-1:0]      req_s1_i,
  input  logic [XLEN*NUM_REQ-1:0]      req_s2_i,
  output logic                         rsp_vld_o,
  input  logic                         rsp_rdy_i,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id_o,
  output logic [XLEN-1:0]              rsp_rslt_o,
  output logic                         rsp_lt_o,
  output logic                         rsp_err_o
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_rslt_q, rsp_rslt_d;
  logic            rsp_lt_q, rsp_lt_d;
  logic            rsp_err_q, rsp_err_d;

  logic            slot_free;
  logic            found;
  logic            gnt_any;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  gnt_idx;

  logic [1:0]      op_sel;
  logic            uns_sel;
  logic [XLEN-1:0] s1_sel, s2_sel;
  logic [XLEN-1:0] sum;
  logic [XLEN:0]   diff;

  assign slot_free = ~rsp_vld_q | rsp_rdy_i;

  // First asserted valid at or after ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    cand    = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req_vld_i[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_any   = found & slot_free & ~rst_i;
    req_rdy_o = '0;
    if (gnt_any) req_rdy_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    op_sel  = '0;
    uns_sel = 1'b0;
    s1_sel  = '0;
    s2_sel  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        op_sel  = req_op_i[2*i +: 2];
        uns_sel = req_uns_i[i];
        s1_sel  = req_s1_i[XLEN*i +: XLEN];
        s2_sel  = req_s2_i[XLEN*i +: XLEN];
      end
    end
  end

  // One extra bit: zero-extended it is the borrow, sign-extended it is the signed less-than.
  assign sum  = s1_sel + s2_sel;
  assign diff = {~uns_sel & s1_sel[XLEN-1], s1_sel} - {~uns_sel & s2_sel[XLEN-1], s2_sel};

  always_comb begin
    ptr_d      = ptr_q;
    rsp_vld_d  = rsp_vld_q;
    rsp_id_d   = rsp_id_q;
    rsp_rslt_d = rsp_rslt_q;
    rsp_lt_d   = rsp_lt_q;
    rsp_err_d  = rsp_err_q;
    if (gnt_any) begin
      rsp_vld_d = 1'b1;
      rsp_id_d  = gnt_idx;
      ptr_d     = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
      case (op_sel)
        2'b01: begin
          rsp_rslt_d = sum;
          rsp_lt_d   = 1'b0;
          rsp_err_d  = 1'b0;
        end
        2'b10: begin
          rsp_rslt_d = diff[XLEN-1:0];
          rsp_lt_d   = diff[XLEN];
          rsp_err_d  = 1'b0;
        end
        default: begin
          rsp_rslt_d = '0;
          rsp_lt_d   = 1'b0;
          rsp_err_d  = 1'b1;
        end
      endcase
    end else if (rsp_rdy_i) begin
      rsp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_rslt_q <= '0;
      rsp_lt_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_id_q   <= rsp_id_d;
      rsp_rslt_q <= rsp_rslt_d;
      rsp_lt_q   <= rsp_lt_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_vld_o  = rsp_vld_q;
  assign rsp_id_o   = rsp_id_q;
  assign rsp_rslt_o = rsp_rslt_q;
  assign rsp_lt_o   = rsp_lt_q;
  assign rsp_err_o  = rsp_err_q;

endmodule
